// File: rtl/lsu.sv
// lsu: load/store unit bridging execute to register writeback over a valid/ready data bus
module lsu #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_WIDTH-1:0]     alu_result,
  input  logic                      d_regW,
  input  logic [REG_ADDR_WIDTH-1:0] d_regAddr,
  input  logic [2:0]                load_inst,
  input  logic [3:0]                store_mask,
  input  logic [DATA_WIDTH-1:0]     store_data,
  output logic                      mem_req_valid,
  input  logic                      mem_req_ready,
  output logic                      mem_req_wen,
  output logic [ADDR_WIDTH-1:0]     mem_req_addr,
  output logic [DATA_WIDTH-1:0]     mem_req_wdata,
  output logic [3:0]                mem_req_wmask,
  input  logic                      mem_resp_valid,
  output logic                      mem_resp_ready,
  input  logic [DATA_WIDTH-1:0]     mem_resp_rdata,
  input  logic                      mem_resp_err,
  output logic                      w_regW,
  output logic [REG_ADDR_WIDTH-1:0] w_regAddr,
  output logic [DATA_WIDTH-1:0]     w_regData,
  output logic                      out_valid,
  output logic                      exc_misalign,
  output logic                      exc_bus
);
  localparam logic [1:0] IDLE = 2'd0, REQ = 2'd1, RESP = 2'd2, WB = 2'd3;
  logic [1:0] state;
  logic [DATA_WIDTH-1:0] addr, sdata, wb_data, sh, proc;
  logic [REG_ADDR_WIDTH-1:0] rd, wb_addr;
  logic [3:0] smask;
  logic [2:0] ld;
  logic regw, mis, err, ld_q, st_q;
  logic is_ld, is_st, half, word, misal, go_bus;
  always_comb begin
    is_ld = (load_inst != 3'd0) && (load_inst < 3'd6);
    is_st = !is_ld && (store_mask == 4'h1 || store_mask == 4'h3 || store_mask == 4'hf);
    half = is_ld ? (load_inst == 3'd2 || load_inst == 3'd5) : (is_st && store_mask == 4'h3);
    word = is_ld ? (load_inst == 3'd3) : (is_st && store_mask == 4'hf);
    misal = (half & alu_result[0]) | (word & |alu_result[1:0]);
    go_bus = (is_ld | is_st) & ~misal;
    sh = mem_resp_rdata >> {addr[1:0], 3'b000};
    proc = ld == 3'd1 ? {{(DATA_WIDTH-8){sh[7]}}, sh[7:0]} :
           ld == 3'd2 ? {{(DATA_WIDTH-16){sh[15]}}, sh[15:0]} :
           ld == 3'd4 ? {{(DATA_WIDTH-8){1'b0}}, sh[7:0]} :
           ld == 3'd5 ? {{(DATA_WIDTH-16){1'b0}}, sh[15:0]} : sh;
  end
  assign in_ready = state == IDLE;
  assign mem_req_valid = state == REQ;
  assign mem_resp_ready = state == RESP;
  assign out_valid = state == WB;
  assign mem_req_wen = st_q;
  assign mem_req_addr = addr[ADDR_WIDTH-1:0];
  assign mem_req_wmask = st_q ? smask << addr[1:0] : 4'h0;
  assign mem_req_wdata = st_q ? sdata << {addr[1:0], 3'b000} : '0;
  assign w_regW = out_valid & regw & ~mis & ~err & ~st_q;
  assign exc_misalign = out_valid & mis;
  assign exc_bus = out_valid & err;
  assign w_regAddr = wb_addr;
  assign w_regData = wb_data;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      addr <= '0;
      sdata <= '0;
      smask <= '0;
      ld <= '0;
      rd <= '0;
      regw <= 1'b0;
      mis <= 1'b0;
      err <= 1'b0;
      ld_q <= 1'b0;
      st_q <= 1'b0;
      wb_addr <= '0;
      wb_data <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          addr <= alu_result;
          sdata <= store_data;
          smask <= store_mask;
          ld <= load_inst;
          rd <= d_regAddr;
          regw <= d_regW;
          mis <= misal;
          err <= 1'b0;
          ld_q <= is_ld;
          st_q <= is_st;
          state <= go_bus ? REQ : WB;
          if (!go_bus) begin
            wb_addr <= d_regAddr;
            wb_data <= alu_result;
          end
        end
        REQ: if (mem_req_ready) state <= RESP;
        RESP: if (mem_resp_valid) begin
          err <= mem_resp_err;
          wb_addr <= rd;
          wb_data <= ld_q ? proc : addr;
          state <= WB;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lsu.sv
// tb_lsu: directed bench with a writeback scoreboard and a simple stalling bus responder
module tb_lsu;
  logic clk = 0, rst = 1;
  logic in_valid = 0, d_regW = 0, mem_req_ready = 0, mem_resp_valid = 0, mem_resp_err = 0;
  logic [31:0] alu_result = 0, store_data = 0, mem_resp_rdata = 32'h80FF_7F01;
  logic [4:0] d_regAddr = 0;
  logic [2:0] load_inst = 0;
  logic [3:0] store_mask = 0;
  logic in_ready, mem_req_valid, mem_req_wen, mem_resp_ready, w_regW, out_valid, exc_misalign, exc_bus;
  logic [31:0] mem_req_addr, mem_req_wdata, w_regData;
  logic [3:0] mem_req_wmask;
  logic [4:0] w_regAddr;
  int errors = 0, checks = 0;
  typedef struct {int lat; logic w; logic [4:0] a; logic [31:0] d; logic chkd; logic mis; logic bus;} wb_t;
  wb_t sb[$];

  lsu dut (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .alu_result(alu_result),
    .d_regW(d_regW), .d_regAddr(d_regAddr), .load_inst(load_inst), .store_mask(store_mask),
    .store_data(store_data), .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_wen(mem_req_wen), .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata),
    .mem_req_wmask(mem_req_wmask), .mem_resp_valid(mem_resp_valid), .mem_resp_ready(mem_resp_ready),
    .mem_resp_rdata(mem_resp_rdata), .mem_resp_err(mem_resp_err), .w_regW(w_regW),
    .w_regAddr(w_regAddr), .w_regData(w_regData), .out_valid(out_valid),
    .exc_misalign(exc_misalign), .exc_bus(exc_bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic run(input logic [2:0] ld, input logic [3:0] msk, input logic [31:0] alu, input logic [31:0] sd,
                     input logic rw, input logic [4:0] rd, input int rstall, input logic err, input logic early,
                     input int lat, input logic exp_req, input logic [3:0] exp_wm, input logic [31:0] exp_wd,
                     input logic exp_w, input logic [31:0] exp_d, input logic chkd, input logic exp_mis, input logic exp_bus);
    wb_t e;
    int nreq;
    bit done;
    logic [68:0] first;
    @(negedge clk);
    chk("idle_ready", in_ready, 1);
    load_inst = ld; store_mask = msk; alu_result = alu; store_data = sd; d_regW = rw; d_regAddr = rd; in_valid = 1;
    sb.push_back('{lat: lat, w: exp_w, a: rd, d: exp_d, chkd: chkd, mis: exp_mis, bus: exp_bus});
    @(posedge clk);
    #1 in_valid = 0; load_inst = 0; store_mask = 0; alu_result = 32'hDEAD_BEEF; store_data = 32'h5555_5555; d_regW = 0;
    nreq = 0; done = 0; first = '0;
    for (int k = 1; k <= 30 && !done; k++) begin
      @(negedge clk);
      if (mem_req_valid) begin
        if (nreq == 0) begin
          first = {mem_req_wen, mem_req_addr, mem_req_wdata, mem_req_wmask};
          chk("req_fields", first, {(msk != 0 && ld == 0), alu, exp_wd, exp_wm});
        end else chk("req_stable", {mem_req_wen, mem_req_addr, mem_req_wdata, mem_req_wmask}, first);
        mem_req_ready = (nreq >= rstall);
        nreq++;
      end else mem_req_ready = 0;
      mem_resp_valid = mem_resp_ready | (early & mem_req_valid);
      mem_resp_err = err & mem_resp_ready;
      if (out_valid) begin
        e = sb.pop_front();
        chk("wb_latency", k, e.lat);
        chk("wb_regW", w_regW, e.w);
        chk("wb_addr", w_regAddr, e.a);
        if (e.chkd) chk("wb_data", w_regData, e.d);
        chk("exc_misalign", exc_misalign, e.mis);
        chk("exc_bus", exc_bus, e.bus);
        done = 1;
      end
    end
    if (!done) chk("wb_timeout", 0, 1);
    chk("req_seen", nreq > 0, exp_req);
    mem_req_ready = 0; mem_resp_valid = 0; mem_resp_err = 0;
    @(negedge clk);
    chk("wb_pulse", {out_valid, w_regW, exc_misalign, exc_bus, in_ready}, 5'b00001);
  endtask

  initial begin
    #12;
    chk("rst_ready", in_ready, 1);
    chk("rst_ctrl", {mem_req_valid, mem_resp_ready, out_valid, w_regW, exc_misalign, exc_bus}, 0);
    chk("rst_data", {mem_req_addr, w_regData, mem_req_wdata, mem_req_wmask, w_regAddr}, 0);
    @(negedge clk) rst = 0;
    run(3'b000, 4'h0, 32'h1234_5678, 0, 1, 5'd5, 0, 0, 0, 1, 0, 4'h0, 0, 1, 32'h1234_5678, 1, 0, 0);
    run(3'b001, 4'h0, 32'h8000_0083, 0, 1, 5'd6, 0, 0, 0, 3, 1, 4'h0, 0, 1, 32'hFFFF_FF80, 1, 0, 0);
    run(3'b100, 4'h0, 32'h8000_0083, 0, 1, 5'd7, 0, 0, 0, 3, 1, 4'h0, 0, 1, 32'h0000_0080, 1, 0, 0);
    run(3'b010, 4'h0, 32'h8000_0082, 0, 1, 5'd8, 0, 0, 0, 3, 1, 4'h0, 0, 1, 32'hFFFF_80FF, 1, 0, 0);
    run(3'b101, 4'h0, 32'h8000_0082, 0, 1, 5'd9, 0, 0, 0, 3, 1, 4'h0, 0, 1, 32'h0000_80FF, 1, 0, 0);
    run(3'b011, 4'h0, 32'h8000_0080, 0, 1, 5'd10, 0, 0, 0, 3, 1, 4'h0, 0, 1, 32'h80FF_7F01, 1, 0, 0);
    run(3'b000, 4'h1, 32'h8000_0001, 32'hAB, 1, 5'd11, 0, 0, 0, 3, 1, 4'b0010, 32'h0000_AB00, 0, 0, 0, 0, 0);
    run(3'b000, 4'h3, 32'h8000_0002, 32'hBEEF, 1, 5'd12, 0, 0, 0, 3, 1, 4'b1100, 32'hBEEF_0000, 0, 0, 0, 0, 0);
    run(3'b011, 4'h0, 32'h8000_0002, 0, 1, 5'd13, 0, 0, 0, 1, 0, 4'h0, 0, 0, 0, 0, 1, 0);
    run(3'b010, 4'h0, 32'h8000_0001, 0, 1, 5'd14, 0, 0, 0, 1, 0, 4'h0, 0, 0, 0, 0, 1, 0);
    run(3'b011, 4'h0, 32'h8000_0080, 0, 1, 5'd15, 3, 1, 1, 6, 1, 4'h0, 0, 0, 0, 0, 0, 1);
    run(3'b011, 4'hF, 32'h8000_0080, 32'h1111_1111, 1, 5'd16, 0, 0, 0, 3, 1, 4'h0, 0, 1, 32'h80FF_7F01, 1, 0, 0);
    run(3'b110, 4'h5, 32'hCAFE_0001, 0, 1, 5'd0, 0, 0, 0, 1, 0, 4'h0, 0, 1, 32'hCAFE_0001, 1, 0, 0);
    @(negedge clk);
    load_inst = 3'b011; alu_result = 32'h8000_0080; d_regW = 1; d_regAddr = 5'd20; in_valid = 1;
    @(posedge clk);
    #1 in_valid = 0; load_inst = 0;
    @(negedge clk) mem_req_ready = 1;
    @(negedge clk) mem_req_ready = 0;
    chk("resp_state", mem_resp_ready, 1);
    #2 rst = 1;
    #1 chk("rst_mid_resp", {mem_resp_ready, in_ready}, 2'b01);
    @(negedge clk) rst = 0;
    mem_resp_valid = 1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("no_wb_after_rst", {out_valid, w_regW}, 2'b00);
    end
    mem_resp_valid = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/lsu.md
# lsu

Load/store unit sitting between the execute stage and the register-file write port of the NPC core. It takes the memory-control outputs of the decode stage (load_inst, store_mask, store_data, d_regW, d_regAddr) plus the ALU result. It performs at most one data-bus transaction per instruction over a valid/ready request/response channel. It then emits the single-cycle writeback triple (w_regW, w_regAddr, w_regData) that the decode stage's register file consumes. Non-memory instructions pass through with one cycle of latency.

## Interface
- REG_ADDR_WIDTH, 5, register index width
- ADDR_WIDTH, 32, data-bus address width
- DATA_WIDTH, 32, data width; byte-lane logic is defined for 32 only
- clk  input  1  clock
- rst  input  1  reset; asynchronous, active-high
- in_valid  input  1  upstream instruction valid
- in_ready  output  1  lsu can accept an instruction
- alu_result  input  DATA_WIDTH  effective address for load/store, otherwise the result
- d_regW / d_regAddr  input  1 / REG_ADDR_WIDTH  writeback enable and index from decode
- load_inst  input  3  000 none, 001 lb, 010 lh, 011 lw, 100 lbu, 101 lhu; 110/111 treated as none
- store_mask  input  4  0000 none, 0001 sb, 0011 sh, 1111 sw; any other value treated as none
- store_data  input  DATA_WIDTH  rs2 value, right-aligned
- mem_req_valid / mem_req_ready  output / input  1 / 1  request handshake
- mem_req_wen  output  1  1 = store, 0 = load
- mem_req_addr  output  ADDR_WIDTH  full byte address, unmodified
- mem_req_wdata / mem_req_wmask  output  DATA_WIDTH / 4  lane-shifted store data and byte mask
- mem_resp_valid / mem_resp_ready  input / output  1 / 1  response handshake
- mem_resp_rdata / mem_resp_err  input  DATA_WIDTH / 1  read word; bus error flag
- w_regW / w_regAddr / w_regData  output  1 / REG_ADDR_WIDTH / DATA_WIDTH  register writeback
- out_valid  output  1  instruction retired (one-cycle pulse)
- exc_misalign / exc_bus  output  1 / 1  exception flags, valid only with out_valid

## Operation
- FSM states: IDLE, REQ, RESP, WB.
- IDLE: in_ready=1. On in_valid, capture all inputs.
  - Load or store, aligned: go to REQ.
  - Load or store, misaligned: go to WB with misalign=1, no bus activity.
  - Otherwise: go to WB.
- Misaligned means: lh/lhu/sh with addr[0]=1; lw/sw with addr[1:0]≠0.
- Load and store both active at once is illegal; the load takes priority.
- REQ: mem_req_valid=1. Request fields stay stable until mem_req_ready; on ready, go to RESP.
- RESP: mem_resp_ready=1. On mem_resp_valid, latch processed data and err, then go to WB.
- Store request: wen=1, wmask = store_mask << addr[1:0], wdata = store_data << 8*addr[1:0].
- Load request: wen=0, wmask=0, wdata=0.
- Load data is shifted as rdata >> 8*addr[1:0]. Then:
  - lb/lh sign-extend from bit 7/15.
  - lbu/lhu zero-extend.
  - lw is unmodified.
- WB: out_valid=1. exc_misalign and exc_bus are from the captured flags. Then go to IDLE.
  - w_regW = d_regW & ~misalign & ~bus_err. A store never writes, regardless of d_regW.
  - w_regData = processed load data for a load, else captured alu_result.
  - w_regAddr = captured d_regAddr. x0 writes are passed through; the register file discards them.
- w_regW, out_valid, exc_* are 0 outside WB. w_regAddr/w_regData hold their last value.

## Timing
- Reset (async, any state):
  - state=IDLE, in_ready=1.
  - mem_req_valid=0, mem_resp_ready=0.
  - w_regW=0, out_valid=0, exc_*=0.
  - All data outputs = 0.
  - An in-flight transaction is abandoned; a response arriving after reset is ignored.
- Non-memory instruction: accepted cycle N, w_regW/out_valid in cycle N+1.
- Memory instruction, best case (req_ready in REQ, resp_valid in first RESP cycle):
  - Accepted cycle N; REQ N+1; RESP N+2; WB N+3.
  - Each extra bus stall cycle adds one cycle.
- in_ready=0 in REQ, RESP and WB. There is no back-to-back accept from WB; the next accept is the cycle after WB.
- mem_resp_valid in REQ is ignored. Responses are accepted only in RESP.
- All outputs are registered state decodes or registered data; no combinational path from in_* to mem_* or w_*.

## Test plan
- Reset mid-RESP: assert rst while in RESP -> same cycle mem_resp_ready=0 and in_ready=1. No w_regW pulse ever follows.
- Non-memory pass-through: alu_result=0x1234_5678, d_regW=1, rd=5, load_inst=000, store_mask=0000 -> next cycle w_regW=1, w_regAddr=5, w_regData=0x1234_5678, out_valid=1.
- Loads from word 0x8000_0080 holding 0x80FF_7F01:
  - lb @0x8000_0083 -> w_regData=0xFFFF_FF80.
  - lbu @0x8000_0083 -> w_regData=0x0000_0080.
  - lh @0x8000_0082 -> w_regData=0xFFFF_80FF.
  - lw @0x8000_0080 -> w_regData=0x80FF_7F01.
  - With zero-stall bus, each gives WB at N+3.
- Store lanes: sb store_data=0xAB @0x8000_0001 -> wmask=0010, wdata=0x0000_AB00, w_regW=0. sh store_data=0xBEEF @0x8000_0002 -> wmask=1100, wdata=0xBEEF_0000, w_regW=0.
- Misalign: lw @0x8000_0002 -> mem_req_valid never asserts; out_valid=1 with exc_misalign=1 at N+1; w_regW=0.
- Bus stalls and error: req_ready held low 3 cycles, then resp_valid with err=1 on an lw -> request fields stable throughout, WB at N+6, exc_bus=1, w_regW=0.
